// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite-position fetcher: FSM states, memory layout
// of the six position words and default raster size.
package sprite_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_COMMIT = 2'd3
    } fetch_state_e;

    localparam int unsigned BASE_ADDR_DEFAULT = 6000;
    localparam int unsigned WORD_STRIDE       = 4;
    localparam int unsigned NUM_WORDS         = 6;

    localparam int unsigned MX_I  = 0;
    localparam int unsigned MY_I  = 1;
    localparam int unsigned P1X_I = 2;
    localparam int unsigned P1Y_I = 3;
    localparam int unsigned P2X_I = 4;
    localparam int unsigned P2Y_I = 5;

    localparam int unsigned H_RES_DEFAULT = 640;
    localparam int unsigned V_RES_DEFAULT = 480;

endpackage

// File: rtl/sprite_fetch_pos_clamp.sv
// Combinational clamp of one position word to the visible raster; X words are
// limited to H_RES-1 and Y words to V_RES-1, compared as unsigned values.
module pos_clamp #(
    parameter int WIDTH = 16,
    parameter int H_RES = 640,
    parameter int V_RES = 480
) (
    input  logic [WIDTH-1:0] value,
    input  logic             is_x,
    output logic [WIDTH-1:0] clamped
);

    localparam logic [WIDTH-1:0] X_MAX = WIDTH'(H_RES - 1);
    localparam logic [WIDTH-1:0] Y_MAX = WIDTH'(V_RES - 1);

    always_comb begin
        clamped = value;
        if (is_x && (value > X_MAX)) begin
            clamped = X_MAX;
        end else if (!is_x && (value > Y_MAX)) begin
            clamped = Y_MAX;
        end
    end

endmodule

// File: rtl/sprite_fetch.sv
// Frame-synchronous fetch of the six sprite positions from memory port A, with
// clamping on capture and an atomic commit to the renderer-facing registers.
module sprite_fetch
    import sprite_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int BASE_ADDR = BASE_ADDR_DEFAULT,
    parameter int H_RES     = H_RES_DEFAULT,
    parameter int V_RES     = V_RES_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_start,
    output logic [WIDTH-1:0] mem_addr,
    input  logic [WIDTH-1:0] mem_data,
    output logic [WIDTH-1:0] mx,
    output logic [WIDTH-1:0] my,
    output logic [WIDTH-1:0] p1x,
    output logic [WIDTH-1:0] p1y,
    output logic [WIDTH-1:0] p2x,
    output logic [WIDTH-1:0] p2y,
    output logic             busy,
    output logic             frame_ready,
    output logic             overrun
);

    localparam logic [WIDTH-1:0] BASE_W   = WIDTH'(BASE_ADDR);
    localparam logic [2:0]       LAST_IDX = 3'(NUM_WORDS - 1);

    fetch_state_e     state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic             cap_vld_q, cap_vld_d;
    logic [2:0]       cap_idx_q, cap_idx_d;
    logic [WIDTH-1:0] work_q [NUM_WORDS];
    logic [WIDTH-1:0] work_d [NUM_WORDS];
    logic [WIDTH-1:0] mx_q, mx_d, my_q, my_d, p1x_q, p1x_d;
    logic [WIDTH-1:0] p1y_q, p1y_d, p2x_q, p2x_d, p2y_q, p2y_d;
    logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic             busy_q, busy_d;
    logic             frame_ready_q, frame_ready_d;
    logic             overrun_q, overrun_d;
    logic [WIDTH-1:0] clamp_val;

    pos_clamp #(
        .WIDTH (WIDTH),
        .H_RES (H_RES),
        .V_RES (V_RES)
    ) u_clamp (
        .value   (mem_data),
        .is_x    (~cap_idx_q[0]),
        .clamped (clamp_val)
    );

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cap_vld_d     = (state_q == ST_FETCH);
        cap_idx_d     = idx_q;
        work_d        = work_q;
        mx_d          = mx_q;
        my_d          = my_q;
        p1x_d         = p1x_q;
        p1y_d         = p1y_q;
        p2x_d         = p2x_q;
        p2y_d         = p2y_q;
        frame_ready_d = 1'b0;
        overrun_d     = overrun_q;

        // RAM data lags its address by one cycle, so capture uses the delayed index
        if (cap_vld_q) begin
            work_d[cap_idx_q] = clamp_val;
        end

        if (frame_start && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    state_d = ST_FETCH;
                    idx_d   = 3'd0;
                end
            end
            ST_FETCH: begin
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DRAIN;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            ST_DRAIN: begin
                state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                mx_d          = work_q[MX_I];
                my_d          = work_q[MY_I];
                p1x_d         = work_q[P1X_I];
                p1y_d         = work_q[P1Y_I];
                p2x_d         = work_q[P2X_I];
                p2y_d         = work_q[P2Y_I];
                frame_ready_d = 1'b1;
                state_d       = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d     = (state_d != ST_IDLE);
        mem_addr_d = (state_d == ST_FETCH)
                   ? BASE_W + WIDTH'(32'(idx_d) * WORD_STRIDE)
                   : BASE_W;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            cap_vld_q     <= 1'b0;
            cap_idx_q     <= '0;
            for (int i = 0; i < NUM_WORDS; i++) begin
                work_q[i] <= '0;
            end
            mx_q          <= '0;
            my_q          <= '0;
            p1x_q         <= '0;
            p1y_q         <= '0;
            p2x_q         <= '0;
            p2y_q         <= '0;
            mem_addr_q    <= BASE_W;
            busy_q        <= 1'b0;
            frame_ready_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cap_vld_q     <= cap_vld_d;
            cap_idx_q     <= cap_idx_d;
            work_q        <= work_d;
            mx_q          <= mx_d;
            my_q          <= my_d;
            p1x_q         <= p1x_d;
            p1y_q         <= p1y_d;
            p2x_q         <= p2x_d;
            p2y_q         <= p2y_d;
            mem_addr_q    <= mem_addr_d;
            busy_q        <= busy_d;
            frame_ready_q <= frame_ready_d;
            overrun_q     <= overrun_d;
        end
    end

    assign mem_addr    = mem_addr_q;
    assign mx          = mx_q;
    assign my          = my_q;
    assign p1x         = p1x_q;
    assign p1y         = p1y_q;
    assign p2x         = p2x_q;
    assign p2y         = p2y_q;
    assign busy        = busy_q;
    assign frame_ready = frame_ready_q;
    assign overrun     = overrun_q;

endmodule
